rf_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32b dual-read/single-write register file. It arbitrates that port between the in-order pipeline writeback and result returns from multicycle units (divider, image coprocessor).
- Keeps a per-register pending scoreboard so decode stalls on RAW/WAW hazards against outstanding multicycle results.
- Sits between the writeback stage, the multicycle-unit return bus and the register file write inputs (RD, DEST_DATA, WEN).

---
 rtl/rf_wb_arbiter_pkg.sv | 13 +
 rtl/rf_wb_arbiter_if.sv | 42 ++++
 rtl/rf_wb_arbiter_fifo.sv | 53 +++++
 rtl/rf_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and the writeback request record for the register-file write port.
package rf_wb_arbiter_pkg;

    localparam int BITS     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [BITS-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of writeback, issue, multicycle-return, decode and register-file signals.
interface rf_wb_arbiter_if;
    import rf_wb_arbiter_pkg::*;

    logic              wb_wen;
    logic [REG_AW-1:0] wb_rd;
    logic [BITS-1:0]   wb_data;
    logic              wb_hold;

    logic              iss_vld;
    logic [REG_AW-1:0] iss_rd;
    logic              iss_rdy;

    logic              mc_vld;
    logic [REG_AW-1:0] mc_rd;
    logic [BITS-1:0]   mc_data;
    logic              mc_rdy;

    logic [REG_AW-1:0] dec_sr1;
    logic [REG_AW-1:0] dec_sr2;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_stall;

    logic              rf_wen;
    logic [REG_AW-1:0] rf_rd;
    logic [BITS-1:0]   rf_data;

    // Arbiter side
    modport slave (
        input  wb_wen, wb_rd, wb_data, iss_vld, iss_rd, mc_vld, mc_rd, mc_data,
               dec_sr1, dec_sr2, dec_rd,
        output wb_hold, iss_rdy, mc_rdy, dec_stall, rf_wen, rf_rd, rf_data
    );

    // Pipeline / multicycle-unit side
    modport master (
        output wb_wen, wb_rd, wb_data, iss_vld, iss_rd, mc_vld, mc_rd, mc_data,
               dec_sr1, dec_sr2, dec_rd,
        input  wb_hold, iss_rdy, mc_rdy, dec_stall, rf_wen, rf_rd, rf_data
    );

endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// Small synchronous FIFO buffering multicycle results until the write port is free.
module rf_wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t dout,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign dout    = mem[rptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs buffered multicycle
// results, with a pending scoreboard for decode hazard detection.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int MC_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    rf_wb_arbiter_if.slave  bus
);
    localparam int OW = $clog2(MC_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX) + 1;

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_set;
    logic [NUM_REGS-1:0] pend_clr;
    logic [NUM_REGS-1:0] pend_eff;
    logic [NUM_REGS-1:0] pend_nxt;
    logic [OW-1:0]       outst;
    logic [SW-1:0]       starve_cnt;
    logic                hold_q;

    wb_req_t head;
    wb_req_t push_req;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    logic    pop;
    logic    wb_eff;
    logic    iss_acc;

    // Results to r0 are acknowledged but never buffered.
    assign push          = bus.mc_vld & bus.mc_rdy & (bus.mc_rd != '0);
    assign push_req.rd   = bus.mc_rd;
    assign push_req.data = bus.mc_data;

    rf_wb_fifo #(.DEPTH(MC_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_req),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.mc_rdy  = ~fifo_full;
    assign bus.wb_hold = hold_q;
    assign bus.iss_rdy = (outst < OW'(MC_DEPTH));
    assign iss_acc     = bus.iss_vld & bus.iss_rdy & (bus.iss_rd != '0);
    assign wb_eff      = bus.wb_wen & (bus.wb_rd != '0) & ~hold_q;

    // Write-port mux: pipeline writeback first, otherwise drain the result buffer.
    always_comb begin
        pop         = 1'b0;
        bus.rf_wen  = 1'b0;
        bus.rf_rd   = '0;
        bus.rf_data = '0;
        if (wb_eff) begin
            bus.rf_wen  = 1'b1;
            bus.rf_rd   = bus.wb_rd;
            bus.rf_data = bus.wb_data;
        end else if (!fifo_empty) begin
            bus.rf_wen  = 1'b1;
            bus.rf_rd   = head.rd;
            bus.rf_data = head.data;
            pop         = 1'b1;
        end
    end

    // Scoreboard set/clear masks for this cycle.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (iss_acc) pend_set[bus.iss_rd] = 1'b1;
        if (pop)     pend_clr[head.rd]    = 1'b1;
    end

    // The RF bypasses the write-then-read cycle, so a popping register stops stalling now.
    assign pend_eff      = pend & ~pend_clr;
    assign pend_nxt      = pend_eff | pend_set;
    assign bus.dec_stall = pend_eff[bus.dec_sr1] | pend_eff[bus.dec_sr2] | pend_eff[bus.dec_rd];

    // Pending bits; set wins over clear, r0 never pending.
    always_ff @(posedge clk) begin
        if (!rst_n) pend <= '0;
        else        pend <= {pend_nxt[NUM_REGS-1:1], 1'b0};
    end

    // Outstanding multicycle ops: issued but not yet written back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outst <= '0;
        end else begin
            case ({iss_acc, pop})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
        end
    end

    // Starvation: after STARVE_MAX-1 waiting cycles, hold WB for one cycle to force a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            hold_q     <= 1'b0;
        end else if (!fifo_empty && !pop) begin
            starve_cnt <= starve_cnt + 1'b1;
            hold_q     <= (starve_cnt == SW'(STARVE_MAX - 2));
        end else begin
            starve_cnt <= '0;
            hold_q     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table plus hand-written
// multicycle sequences; every RF write is matched against a queue of expected writes.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    wb_req_t exq[$];

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  sr1;
        logic [4:0]  sr2;
        logic [4:0]  drd;
        logic        e_wen;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_stall;
    } vec_t;

    vec_t vt[6];

    always #5 clk = ~clk;

    rf_wb_arbiter_if bus();

    rf_wb_arbiter #(.MC_DEPTH(4), .STARVE_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.wb_wen  = 1'b0;
        bus.wb_rd   = '0;
        bus.wb_data = '0;
        bus.iss_vld = 1'b0;
        bus.iss_rd  = '0;
        bus.mc_vld  = 1'b0;
        bus.mc_rd   = '0;
        bus.mc_data = '0;
        bus.dec_sr1 = '0;
        bus.dec_sr2 = '0;
        bus.dec_rd  = '0;
    endtask

    task automatic expw(input logic [4:0] rd, input logic [31:0] d);
        wb_req_t e;
        e.rd   = rd;
        e.data = d;
        exq.push_back(e);
    endtask

    // Scoreboard: every RF write outside reset must match the next expected write.
    always @(negedge clk) begin
        wb_req_t e;
        if (rst_n && bus.rf_wen) begin
            if (exq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h want none", bus.rf_rd, bus.rf_data);
            end else begin
                e = exq.pop_front();
                chk("wr_rd", 32'(bus.rf_rd), 32'(e.rd));
                chk("wr_data", bus.rf_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got no finish want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        vt[0] = '{1'b1, 5'd10, 32'h0000AAAA, 5'd12, 5'd0,  5'd0,  1'b1, 5'd10, 32'h0000AAAA, 1'b1};
        vt[1] = '{1'b0, 5'd10, 32'h0000BBBB, 5'd0,  5'd20, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1};
        vt[2] = '{1'b1, 5'd0,  32'h0000CCCC, 5'd0,  5'd0,  5'd20, 1'b0, 5'd0,  32'h0,        1'b1};
        vt[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd11, 5'd13, 5'd19, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};
        vt[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0};
        vt[5] = '{1'b1, 5'd1,  32'h00001234, 5'd21, 5'd12, 5'd1,  1'b1, 5'd1,  32'h00001234, 1'b1};

        // Reset with random inputs, then release with idle inputs
        idle();
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.wb_wen  = 1'($urandom);
            bus.wb_rd   = 5'($urandom);
            bus.wb_data = $urandom;
            bus.iss_vld = 1'($urandom);
            bus.iss_rd  = 5'($urandom);
            bus.mc_vld  = 1'($urandom);
            bus.mc_rd   = 5'($urandom);
            bus.mc_data = $urandom;
            bus.dec_sr1 = 5'($urandom);
            bus.dec_sr2 = 5'($urandom);
            bus.dec_rd  = 5'($urandom);
            tick();
        end
        idle();
        tick();
        rst_n = 1'b1;
        bus.dec_sr1 = 5'd5;
        bus.dec_sr2 = 5'd9;
        bus.dec_rd  = 5'd31;
        settle();
        chk("rst_wb_hold", bus.wb_hold, 0);
        chk("rst_iss_rdy", bus.iss_rdy, 1);
        chk("rst_mc_rdy", bus.mc_rdy, 1);
        chk("rst_dec_stall", bus.dec_stall, 0);
        chk("rst_rf_wen", bus.rf_wen, 0);
        chk("rst_rf_rd", 32'(bus.rf_rd), 0);
        chk("rst_rf_data", bus.rf_data, 0);
        tick();

        // Issue rd=5, return DEADBEEF, observe stall then write with bypass
        idle();
        bus.iss_vld = 1'b1;
        bus.iss_rd  = 5'd5;
        settle();
        chk("t2_iss_rdy", bus.iss_rdy, 1);
        tick();
        idle();
        bus.dec_sr1 = 5'd5;
        bus.mc_vld  = 1'b1;
        bus.mc_rd   = 5'd5;
        bus.mc_data = 32'hDEADBEEF;
        expw(5'd5, 32'hDEADBEEF);
        settle();
        chk("t2_stall_pend", bus.dec_stall, 1);
        chk("t2_mc_rdy", bus.mc_rdy, 1);
        chk("t2_no_write_yet", bus.rf_wen, 0);
        tick();
        bus.mc_vld = 1'b0;
        settle();
        chk("t2_rf_wen", bus.rf_wen, 1);
        chk("t2_rf_rd", 32'(bus.rf_rd), 5);
        chk("t2_rf_data", bus.rf_data, 32'hDEADBEEF);
        chk("t2_stall_bypass", bus.dec_stall, 0);
        tick();
        settle();
        chk("t2_idle_wen", bus.rf_wen, 0);
        chk("t2_stall_after", bus.dec_stall, 0);
        tick();

        // Starvation: WB busy on rd=3, one buffered rd=7
        idle();
        bus.iss_vld = 1'b1;
        bus.iss_rd  = 5'd7;
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            bus.wb_wen  = 1'b1;
            bus.wb_rd   = 5'd3;
            bus.wb_data = 32'h3000 + i;
            bus.mc_vld  = (i == 0);
            bus.mc_rd   = 5'd7;
            bus.mc_data = 32'h77;
            if (i == 8) expw(5'd7, 32'h77);
            else        expw(5'd3, 32'h3000 + i);
            settle();
            chk($sformatf("t3_hold_%0d", i), bus.wb_hold, (i == 8));
            tick();
        end

        // Outstanding limit, rejected issue, FIFO full, drain
        for (int i = 1; i <= 4; i++) begin
            idle();
            bus.iss_vld = 1'b1;
            bus.iss_rd  = 5'(i);
            settle();
            chk($sformatf("t4_iss_rdy_%0d", i), bus.iss_rdy, 1);
            tick();
        end
        idle();
        bus.iss_vld = 1'b1;
        bus.iss_rd  = 5'd6;
        bus.dec_rd  = 5'd3;
        settle();
        chk("t4_iss_rdy_full", bus.iss_rdy, 0);
        chk("t4_stall_rd3", bus.dec_stall, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle();
            bus.wb_wen  = 1'b1;
            bus.wb_rd   = 5'd3;
            bus.wb_data = 32'h4000 + i;
            expw(5'd3, 32'h4000 + i);
            bus.mc_vld  = 1'b1;
            bus.mc_rd   = (i < 4) ? 5'(i + 1) : 5'd2;
            bus.mc_data = 32'h100 + i;
            settle();
            chk($sformatf("t4_mc_rdy_%0d", i), bus.mc_rdy, (i < 4));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            expw(5'(i + 1), 32'h100 + i);
            settle();
            chk($sformatf("t4_drain_rd_%0d", i), 32'(bus.rf_rd), i + 1);
            if (i == 0) chk("t4_iss_rdy_pop", bus.iss_rdy, 0);
            if (i == 1) chk("t4_iss_rdy_back", bus.iss_rdy, 1);
            tick();
        end
        idle();
        bus.dec_sr1 = 5'd6;
        settle();
        chk("t4_rejected_not_pend", bus.dec_stall, 0);
        tick();

        // Same-cycle pop and re-issue of rd=9: set wins
        idle();
        bus.iss_vld = 1'b1;
        bus.iss_rd  = 5'd9;
        tick();
        idle();
        bus.mc_vld  = 1'b1;
        bus.mc_rd   = 5'd9;
        bus.mc_data = 32'h9001;
        expw(5'd9, 32'h9001);
        tick();
        idle();
        bus.iss_vld = 1'b1;
        bus.iss_rd  = 5'd9;
        bus.dec_sr2 = 5'd9;
        settle();
        chk("t5_pop9", 32'(bus.rf_rd), 9);
        chk("t5_iss_rdy", bus.iss_rdy, 1);
        tick();
        idle();
        bus.dec_sr2 = 5'd9;
        settle();
        chk("t5_stall_set_wins", bus.dec_stall, 1);
        bus.mc_vld  = 1'b1;
        bus.mc_rd   = 5'd9;
        bus.mc_data = 32'h9002;
        expw(5'd9, 32'h9002);
        tick();
        idle();
        bus.dec_sr2 = 5'd9;
        settle();
        chk("t5_pop9_again", 32'(bus.rf_rd), 9);
        chk("t5_stall_bypass", bus.dec_stall, 0);
        tick();
        settle();
        chk("t5_stall_clear", bus.dec_stall, 0);

        // r0 traffic is dropped everywhere
        idle();
        bus.wb_wen  = 1'b1;
        bus.wb_rd   = 5'd0;
        bus.wb_data = 32'h5555;
        bus.mc_vld  = 1'b1;
        bus.mc_rd   = 5'd0;
        bus.mc_data = 32'h6666;
        bus.iss_vld = 1'b1;
        bus.iss_rd  = 5'd0;
        settle();
        chk("t6_rf_wen", bus.rf_wen, 0);
        chk("t6_mc_rdy", bus.mc_rdy, 1);
        tick();
        idle();
        settle();
        chk("t6_fifo_empty", bus.rf_wen, 0);
        chk("t6_iss_rdy", bus.iss_rdy, 1);
        tick();

        // Vector table with rd=12 and rd=20 pending
        idle();
        bus.iss_vld = 1'b1;
        bus.iss_rd  = 5'd12;
        tick();
        bus.iss_rd  = 5'd20;
        tick();
        idle();
        for (int i = 0; i < 6; i++) begin
            bus.wb_wen  = vt[i].wen;
            bus.wb_rd   = vt[i].rd;
            bus.wb_data = vt[i].data;
            bus.dec_sr1 = vt[i].sr1;
            bus.dec_sr2 = vt[i].sr2;
            bus.dec_rd  = vt[i].drd;
            if (vt[i].e_wen) expw(vt[i].e_rd, vt[i].e_data);
            settle();
            chk($sformatf("vec%0d_wen", i), bus.rf_wen, vt[i].e_wen);
            chk($sformatf("vec%0d_rd", i), 32'(bus.rf_rd), 32'(vt[i].e_rd));
            chk($sformatf("vec%0d_data", i), bus.rf_data, vt[i].e_data);
            chk($sformatf("vec%0d_stall", i), bus.dec_stall, vt[i].e_stall);
            tick();
        end

        // Reset mid-operation discards buffered result and pending bits
        idle();
        bus.wb_wen  = 1'b1;
        bus.wb_rd   = 5'd3;
        bus.wb_data = 32'h7000;
        expw(5'd3, 32'h7000);
        bus.mc_vld  = 1'b1;
        bus.mc_rd   = 5'd12;
        bus.mc_data = 32'hC0;
        tick();
        rst_n = 1'b0;
        idle();
        bus.wb_wen = 1'b1;
        bus.wb_rd  = 5'd3;
        tick();
        rst_n = 1'b1;
        idle();
        bus.dec_sr1 = 5'd12;
        bus.dec_sr2 = 5'd20;
        settle();
        chk("rst2_fifo_flushed", bus.rf_wen, 0);
        chk("rst2_pend_cleared", bus.dec_stall, 0);
        chk("rst2_iss_rdy", bus.iss_rdy, 1);
        tick();

        chk("exq_drained", exq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
